// File: rtl/pot_sampler_pkg.sv
// pot_sampler_pkg: shared FSM encoding, XADC DRP addresses and the 12-bit result mask.
package pot_sampler_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CMP} state_t;
  localparam logic [6:0] DRP_VAUX_BASE = 7'h10;
  localparam logic [6:0] DRP_VAUX3 = 7'h13;
  localparam logic [15:0] RESULT_MASK = 16'hFFF0;
  function automatic logic [6:0] vaux_addr(input logic [3:0] ch);
    return DRP_VAUX_BASE + {3'b000, ch};
  endfunction
endpackage

// File: rtl/pot_sampler_if.sv
// pot_sampler_if: XADC DRP port bundle; master is the sampler, slave is the XADC.
interface pot_sampler_if;
  logic den;
  logic dwe;
  logic [6:0] daddr;
  logic [15:0] di;
  logic drdy;
  logic [15:0] do_drp;
  modport master(output den, dwe, daddr, di, input drdy, do_drp);
  modport slave(input den, dwe, daddr, di, output drdy, do_drp);
endinterface

// File: rtl/pot_avg_accum.sv
// pot_avg_accum: box-car accumulator, window counter and publish decision (hysteresis when POT_SAMPLER_HYST_EN).
module pot_avg_accum
  import pot_sampler_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter logic [15:0] HYST = 16'h0200
) (
  input  logic clk,
  input  logic rst,
  input  logic add,
  input  logic cmp,
  input  logic [15:0] sample,
  output logic full,
  output logic ready,
  output logic [15:0] data_adc
);
  localparam int W = 16 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'((2 ** AVG_LOG2) - 1);
  logic [W-1:0] acc;
  logic [AVG_LOG2:0] cnt;
  logic [15:0] avg, avg_q;
  logic publish, pub_q;
  assign full = cnt == LAST;
  assign avg = 16'(acc >> AVG_LOG2) & RESULT_MASK;
`ifdef POT_SAMPLER_HYST_EN
  logic first;
  logic [16:0] diff;
  assign diff = avg >= data_adc ? {1'b0, avg - data_adc} : {1'b0, data_adc - avg};
  assign publish = first || diff >= {1'b0, HYST};
  always_ff @(posedge clk)
    if (rst) first <= 1'b1;
    else if (cmp && publish) first <= 1'b0;
`else
  assign publish = 1'b1;
`endif
  // Decision is registered in CMP, then published one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      avg_q <= '0;
      pub_q <= 1'b0;
      ready <= 1'b0;
      data_adc <= '0;
    end else begin
      pub_q <= cmp && publish;
      ready <= pub_q;
      if (cmp) begin
        acc <= '0;
        cnt <= '0;
        avg_q <= avg;
      end else if (add) begin
        acc <= acc + W'(sample & RESULT_MASK);
        cnt <= cnt + 1'b1;
      end
      if (pub_q) data_adc <= avg_q;
    end
  end
endmodule

// File: rtl/pot_sampler.sv
// pot_sampler: polls one XADC aux channel over DRP, averages and publishes; hysteresis via POT_SAMPLER_HYST_EN.
module pot_sampler
  import pot_sampler_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int AVG_LOG2 = 3,
  parameter logic [15:0] HYST = 16'h0200,
  parameter logic [6:0] DRP_ADDR = DRP_VAUX3,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  pot_sampler_if.master drp,
  output logic ready,
  output logic [15:0] data_adc,
  output logic timeout_err
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [DW-1:0] div;
  logic [TW-1:0] wcnt;
  logic tick, pending, add, cmp, full;
  assign tick = div == DW'(SAMPLE_DIV - 1);
  assign add = state == S_WAIT && drp.drdy;
  assign cmp = state == S_CMP;
  assign drp.dwe = 1'b0;
  assign drp.di = '0;
  assign drp.daddr = DRP_ADDR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      div <= '0;
      pending <= 1'b0;
      wcnt <= '0;
      drp.den <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      drp.den <= 1'b0;
      if (tick && state != S_IDLE) pending <= 1'b1;
      case (state)
        S_IDLE:
          if (tick || pending) begin
            pending <= 1'b0;
            drp.den <= 1'b1;
            state <= S_REQ;
          end
        S_REQ: begin
          wcnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          if (drp.drdy) state <= full ? S_CMP : S_IDLE;
          else if (wcnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state <= S_IDLE;
          end else wcnt <= wcnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
  pot_avg_accum #(.AVG_LOG2(AVG_LOG2), .HYST(HYST)) u_accum (
    .clk(clk),
    .rst(rst),
    .add(add),
    .cmp(cmp),
    .sample(drp.do_drp),
    .full(full),
    .ready(ready),
    .data_adc(data_adc)
  );
endmodule
